// File: rtl/riscv151_mmio_pkg.sv
// ---------------------------------------------------------------------------
// riscv151_mmio_pkg
// Shared definitions for the memory-mapped I/O region. The MMIO responder
// and the CPU load/store decoder both import this package, so the register
// offsets and the STATUS bit layout have a single source of truth.
//   ADDR_*   : byte offsets within the I/O region (word-aligned)
//   STATUS_* : bit positions inside the STATUS register
// ---------------------------------------------------------------------------
package riscv151_mmio_pkg;

  localparam logic [7:0] ADDR_STATUS  = 8'h00;
  localparam logic [7:0] ADDR_RX_DATA = 8'h04;
  localparam logic [7:0] ADDR_TX_DATA = 8'h08;
  localparam logic [7:0] ADDR_CYCLES  = 8'h10;
  localparam logic [7:0] ADDR_INSTS   = 8'h14;
  localparam logic [7:0] ADDR_CNT_RST = 8'h18;

  localparam int STATUS_TX_NOT_FULL  = 0;
  localparam int STATUS_RX_NOT_EMPTY = 1;
  localparam int STATUS_TX_DROP      = 2;

  // Assembles the STATUS word; every bit not named here reads as zero.
  function automatic logic [31:0] status_word(input logic tx_not_full,
                                              input logic rx_not_empty,
                                              input logic tx_drop);
    logic [31:0] word;
    word = '0;
    word[STATUS_TX_NOT_FULL]  = tx_not_full;
    word[STATUS_RX_NOT_EMPTY] = rx_not_empty;
    word[STATUS_TX_DROP]      = tx_drop;
    return word;
  endfunction

endpackage

// File: rtl/uart_mmio_responder_if.sv
// ---------------------------------------------------------------------------
// uart_mmio_responder_if
// CPU data-memory side bus into the I/O region.
//   mmio_sel   : access targets the I/O region (decoded upstream)
//   mmio_addr  : byte offset within the region, word-aligned
//   mmio_re    : load strobe
//   mmio_we    : full-word store strobe
//   mmio_wdata : store data
//   mmio_rdata : load data, registered, valid the cycle after mmio_re
// master = CPU side, slave = responder side.
// ---------------------------------------------------------------------------
interface uart_mmio_responder_if;

  logic        mmio_sel;
  logic [7:0]  mmio_addr;
  logic        mmio_re;
  logic        mmio_we;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;

  modport master (
    output mmio_sel, mmio_addr, mmio_re, mmio_we, mmio_wdata,
    input  mmio_rdata
  );

  modport slave (
    input  mmio_sel, mmio_addr, mmio_re, mmio_we, mmio_wdata,
    output mmio_rdata
  );

endinterface

// File: rtl/mmio_byte_fifo.sv
// ---------------------------------------------------------------------------
// mmio_byte_fifo
// Synchronous FIFO buffering one UART direction.
//   clk, rst  : core clock, asynchronous active-low reset
//   push      : push request; ignored while full
//   push_data : entry to store
//   pop       : pop request; ignored while empty
//   head      : oldest entry (meaningful only when !empty)
//   full      : DEPTH entries held
//   empty     : no entries held
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// Full/empty are judged on the pre-edge state: a push while full is refused
// even if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module mmio_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  // One extra bit so a full FIFO is distinguishable from an empty one.
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the empty flag guards every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// ---------------------------------------------------------------------------
// uart_mmio_responder
// Answers CPU loads/stores to the I/O region with UART status, RX/TX bytes
// and performance counters. Both UART directions are buffered in FIFOs so
// the CPU never waits on serial timing. Load data is registered, matching
// the data memory's one-cycle latency.
// Ports:
//   clk, rst      : core clock, asynchronous active-low reset
//   bus           : CPU MMIO bus (uart_mmio_responder_if.slave)
//   inst_retired  : one instruction retired this cycle
//   tx_data/tx_valid/tx_ready : byte stream to the UART transmitter
//   rx_data/rx_valid/rx_ready : byte stream from the UART receiver
// Configuration:
//   MMIO_PERF_COUNTERS_EN defined   -> CYCLES/INSTS counters and CNT_RST exist
//   MMIO_PERF_COUNTERS_EN undefined -> no counter flops, 0x10/0x14 read 0
// ---------------------------------------------------------------------------
module uart_mmio_responder
  import riscv151_mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 8,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_mmio_responder_if.slave  bus,
  input  logic                  inst_retired,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);

  logic        rd_qual;
  logic        wr_qual;
  logic        rx_pop_req;
  logic        tx_push_req;
  logic        status_wr;
  logic [7:0]  rx_head;
  logic        rx_full;
  logic        rx_empty;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_drop;
  logic        rx_enable;
  logic [31:0] read_mux;
  logic [31:0] rdata_q;

  assign rd_qual     = bus.mmio_sel && bus.mmio_re;
  assign wr_qual     = bus.mmio_sel && bus.mmio_we;
  assign rx_pop_req  = rd_qual && (bus.mmio_addr == ADDR_RX_DATA);
  assign tx_push_req = wr_qual && (bus.mmio_addr == ADDR_TX_DATA);
  assign status_wr   = wr_qual && (bus.mmio_addr == ADDR_STATUS);

  // rx_ready stays low through reset and rises on the first edge after
  // release, then simply reflects room in the RX FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_enable <= 1'b0;
    else      rx_enable <= 1'b1;
  end

  assign rx_ready = rx_enable && !rx_full;
  assign tx_valid = !tx_empty;

  mmio_byte_fifo #(.DEPTH(RX_FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid && rx_ready),
    .push_data (rx_data),
    .pop       (rx_pop_req),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  mmio_byte_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push_req),
    .push_data (bus.mmio_wdata[7:0]),
    .pop       (tx_valid && tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // Sticky drop flag: a TX write against a full FIFO sets it, and only a
  // STATUS write with bit 2 set clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_drop <= 1'b0;
    end else if (tx_push_req && tx_full) begin
      tx_drop <= 1'b1;
    end else if (status_wr && bus.mmio_wdata[STATUS_TX_DROP]) begin
      tx_drop <= 1'b0;
    end
  end

`ifdef MMIO_PERF_COUNTERS_EN
  logic        cnt_rst_wr;
  logic [31:0] cycle_count;
  logic [31:0] inst_count;

  assign cnt_rst_wr = wr_qual && (bus.mmio_addr == ADDR_CNT_RST);

  // Free-running counters; a CNT_RST write forces both to zero on this edge
  // so counting picks up again from the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else if (cnt_rst_wr) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (inst_retired) inst_count <= inst_count + 32'd1;
    end
  end

  logic unused_wdata_hi;
  assign unused_wdata_hi = ^bus.mmio_wdata[31:8];
`else
  logic unused_inputs;
  assign unused_inputs = ^{bus.mmio_wdata[31:8], inst_retired};
`endif

  // Read mux sees pre-edge state, so a same-cycle write never leaks into
  // the returned value, and an empty RX FIFO reads zero with no bypass.
  always_comb begin
    read_mux = '0;
    case (bus.mmio_addr)
      ADDR_STATUS:  read_mux = status_word(!tx_full, !rx_empty, tx_drop);
      ADDR_RX_DATA: if (!rx_empty) read_mux = {24'b0, rx_head};
`ifdef MMIO_PERF_COUNTERS_EN
      ADDR_CYCLES:  read_mux = cycle_count;
      ADDR_INSTS:   read_mux = inst_count;
`endif
      default:      read_mux = '0;
    endcase
  end

  // Load data register: updates only on a qualified read, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rdata_q <= '0;
    else if (rd_qual) rdata_q <= read_mux;
  end

  assign bus.mmio_rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio_responder
// Directed bench for uart_mmio_responder with hand-computed expectations.
// Honours MMIO_PERF_COUNTERS_EN to pick the expected counter values.
// ---------------------------------------------------------------------------
module tb_uart_mmio_responder;
  import riscv151_mmio_pkg::*;

  logic       clk;
  logic       rst;
  logic       inst_retired;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int check_count;
  int fail_count;

  uart_mmio_responder_if bus ();

  uart_mmio_responder #(.RX_FIFO_DEPTH(8), .TX_FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .inst_retired (inst_retired),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  // 10-unit clock period, active edge is posedge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=0x%08h required=0x%08h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive, take one active edge, sample #1 later, go idle
  task automatic applyStimulus(input logic sel, input logic re, input logic we,
                               input logic [7:0] addr, input logic [31:0] wdata);
    bus.mmio_sel   = sel;
    bus.mmio_re    = re;
    bus.mmio_we    = we;
    bus.mmio_addr  = addr;
    bus.mmio_wdata = wdata;
    @(posedge clk);
    #1;
    bus.mmio_sel   = 1'b0;
    bus.mmio_re    = 1'b0;
    bus.mmio_we    = 1'b0;
    bus.mmio_addr  = 8'h00;
    bus.mmio_wdata = 32'h0;
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr,
                           input logic [31:0] expected);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0);
    checkOutput(tag, bus.mmio_rdata, expected);
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data);
  endtask

  initial begin
    logic [31:0] exp_cycles;
    logic [31:0] exp_insts;
    check_count = 0;
    fail_count  = 0;

    // Reset held with random activity on every input
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.mmio_sel   = 1'($urandom_range(0, 1));
      bus.mmio_re    = 1'($urandom_range(0, 1));
      bus.mmio_we    = 1'($urandom_range(0, 1));
      bus.mmio_addr  = 8'($urandom_range(0, 255));
      bus.mmio_wdata = $urandom;
      inst_retired   = 1'($urandom_range(0, 1));
      tx_ready       = 1'($urandom_range(0, 1));
      rx_valid       = 1'($urandom_range(0, 1));
      rx_data        = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      checkOutput("reset_rdata", bus.mmio_rdata, 32'h0);
      checkOutput("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
      checkOutput("reset_rx_ready", {31'b0, rx_ready}, 32'h0);
    end
    bus.mmio_sel   = 1'b0;
    bus.mmio_re    = 1'b0;
    bus.mmio_we    = 1'b0;
    bus.mmio_addr  = 8'h00;
    bus.mmio_wdata = 32'h0;
    inst_retired   = 1'b0;
    tx_ready       = 1'b0;
    rx_valid       = 1'b0;
    rx_data        = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rx_ready_before_edge", {31'b0, rx_ready}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rx_ready_after_edge", {31'b0, rx_ready}, 32'h1);
    readCheck("status_after_reset", ADDR_STATUS, 32'h1);

    // RX path: two bytes in, read back in order, then empty read gives 0
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(posedge clk);
    #1;
    rx_data  = 8'h42;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    readCheck("status_rx_two", ADDR_STATUS, 32'h3);
    readCheck("rx_read_0x41", ADDR_RX_DATA, 32'h41);
    readCheck("rx_read_0x42", ADDR_RX_DATA, 32'h42);
    readCheck("rx_read_empty", ADDR_RX_DATA, 32'h0);
    readCheck("status_rx_drained", ADDR_STATUS, 32'h1);

    // rdata holds across unqualified reads and writes
    readCheck("status_before_hold", ADDR_STATUS, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, ADDR_TX_DATA, 32'h0);
    checkOutput("hold_unselected_read", bus.mmio_rdata, 32'h1);
    readCheck("unmapped_read", 8'h0C, 32'h0);
    writeReg(8'h20, 32'hFFFF_FFFF);
    checkOutput("hold_after_write", bus.mmio_rdata, 32'h0);

    // TX overflow: 9 writes with the transmitter stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) writeReg(ADDR_TX_DATA, 32'hABCD_0010 + i);
    checkOutput("tx_valid_queued", {31'b0, tx_valid}, 32'h1);
    checkOutput("tx_head_first", {24'b0, tx_data}, 32'h10);
    readCheck("status_tx_full_drop", ADDR_STATUS, 32'h4);
    writeReg(ADDR_STATUS, 32'h4);
    readCheck("status_drop_cleared", ADDR_STATUS, 32'h0);

    // Full FIFO: pop and write in the same cycle, write must be dropped
    tx_ready = 1'b1;
    writeReg(ADDR_TX_DATA, 32'h99);
    tx_ready = 1'b0;
    checkOutput("tx_head_after_pop", {24'b0, tx_data}, 32'h11);
    // Read and write STATUS together: read returns the pre-write value
    applyStimulus(1'b1, 1'b1, 1'b1, ADDR_STATUS, 32'h4);
    checkOutput("status_concurrent_drop", bus.mmio_rdata, 32'h5);
    readCheck("status_post_clear", ADDR_STATUS, 32'h1);

    // Drain in order; the dropped 0x18 and 0x99 never appear
    tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      checkOutput($sformatf("tx_drain_valid_%0d", i), {31'b0, tx_valid}, 32'h1);
      checkOutput($sformatf("tx_drain_data_%0d", i), {24'b0, tx_data}, 32'h10 + i);
      @(posedge clk);
      #1;
    end
    checkOutput("tx_drained_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // RX backpressure: fill 8, hold a 9th, one read frees a slot
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h60 + 8'(i);
      @(posedge clk);
      #1;
    end
    rx_data = 8'h68;
    checkOutput("rx_ready_full", {31'b0, rx_ready}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rx_ready_still_full", {31'b0, rx_ready}, 32'h0);
    readCheck("rx_bp_first", ADDR_RX_DATA, 32'h60);
    checkOutput("rx_ready_after_pop", {31'b0, rx_ready}, 32'h1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    checkOutput("rx_ready_refilled", {31'b0, rx_ready}, 32'h0);
    for (int i = 1; i < 9; i++)
      readCheck($sformatf("rx_bp_read_%0d", i), ADDR_RX_DATA, 32'h60 + i);
    readCheck("rx_bp_empty", ADDR_RX_DATA, 32'h0);
    readCheck("status_final_idle", ADDR_STATUS, 32'h1);

    // Counters: zero them, 100 cycles with inst_retired every other cycle
    writeReg(ADDR_CNT_RST, 32'h1);
    for (int i = 0; i < 100; i++) begin
      inst_retired = (i % 2) == 1;
      @(posedge clk);
      #1;
    end
    inst_retired = 1'b0;
`ifdef MMIO_PERF_COUNTERS_EN
    exp_cycles = 32'd100;
    exp_insts  = 32'd50;
`else
    exp_cycles = 32'd0;
    exp_insts  = 32'd0;
`endif
    readCheck("cycles_count", ADDR_CYCLES, exp_cycles);
    readCheck("insts_count", ADDR_INSTS, exp_insts);
    writeReg(ADDR_CNT_RST, 32'h1);
    readCheck("cycles_after_rst", ADDR_CYCLES, 32'h0);
    readCheck("insts_after_rst", ADDR_INSTS, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
